// File: rtl/digest_display_ctrl_pkg.sv
// Shared types and constants for the digest display controller.
// Also holds the wrap-around word-index stepping helpers.
package digest_display_ctrl_pkg;

    localparam int WORD_W             = 32;
    localparam int SEL_W              = 3;
    localparam int LED_W              = 5;
    localparam int DEFAULT_STEP_TICKS = 100000000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHOW  = 2'd1,
        AUTO  = 2'd2
    } state_t;

    function automatic logic [SEL_W-1:0] sel_forward(input logic [SEL_W-1:0] cur,
                                                     input int num_words);
        return (cur == SEL_W'(num_words - 1)) ? '0 : cur + 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] sel_backward(input logic [SEL_W-1:0] cur,
                                                      input int num_words);
        return (cur == '0) ? SEL_W'(num_words - 1) : cur - 1'b1;
    endfunction

endpackage

// File: rtl/digest_display_ctrl_if.sv
// Control/data bundle between the hash/button side and the display controller.
interface digest_display_ctrl_if #(
    parameter int DIGEST_W = 256
);
    import digest_display_ctrl_pkg::*;

    logic [DIGEST_W-1:0] digest_in;
    logic                digest_valid;
    logic                clear;
    logic                btn_next;
    logic                btn_prev;
    logic                auto_en;
    logic [WORD_W-1:0]   word_out;
    logic [SEL_W-1:0]    sel;
    logic [LED_W-1:0]    led;
    logic                word_valid;

    modport master (
        output digest_in, digest_valid, clear, btn_next, btn_prev, auto_en,
        input  word_out, sel, led, word_valid
    );

    modport slave (
        input  digest_in, digest_valid, clear, btn_next, btn_prev, auto_en,
        output word_out, sel, led, word_valid
    );

endinterface

// File: rtl/digest_display_ctrl_step_timer.sv
// Free-running auto-advance timer: counts 0..STEP_TICKS-1 while run is high,
// pulsing tick on the terminal count.
module step_timer
    import digest_display_ctrl_pkg::*;
#(
    parameter int STEP_TICKS = DEFAULT_STEP_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int              CNT_W = $clog2(STEP_TICKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_TICKS - 1);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (restart || !run || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/digest_display_ctrl.sv
// Holds a captured hash digest and presents one 32-bit word at a time,
// stepped by buttons or by a periodic timer, with a one-hot LED index.
module digest_display_ctrl
    import digest_display_ctrl_pkg::*;
#(
    parameter int DIGEST_W   = 256,
    parameter int NUM_WORDS  = 5,
    parameter int STEP_TICKS = DEFAULT_STEP_TICKS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digest_display_ctrl_if.slave  bus
);

    localparam int HELD_W = NUM_WORDS * WORD_W;

    state_t             state_q, state_d;
    logic [HELD_W-1:0]  digest_q, digest_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               valid_q, valid_d;

    logic [DIGEST_W-1:0] digest_raw;
    logic                unused_digest_bits;
    logic                any_btn;
    logic                timer_run;
    logic                timer_restart;
    logic                tick;

    // Only the displayed words are stored; any extra digest bits are dropped.
    assign digest_raw         = bus.digest_in;
    assign unused_digest_bits = ^digest_raw;
    assign any_btn            = bus.btn_next | bus.btn_prev;
    assign timer_run          = (state_q == AUTO) && bus.auto_en;

    step_timer #(
        .STEP_TICKS (STEP_TICKS)
    ) u_step_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (timer_run),
        .restart (timer_restart),
        .tick    (tick)
    );

    // Priority: clear, then capture, then buttons, then timer tick.
    always_comb begin
        state_d       = state_q;
        digest_d      = digest_q;
        sel_d         = sel_q;
        timer_restart = 1'b0;

        if (bus.clear) begin
            state_d       = EMPTY;
            digest_d      = '0;
            sel_d         = '0;
            timer_restart = 1'b1;
        end else if (bus.digest_valid) begin
            state_d       = bus.auto_en ? AUTO : SHOW;
            digest_d      = digest_raw[HELD_W-1:0];
            sel_d         = '0;
            timer_restart = 1'b1;
        end else if (state_q != EMPTY) begin
            state_d = bus.auto_en ? AUTO : SHOW;
            if (any_btn) begin
                timer_restart = 1'b1;
                if (bus.btn_next && !bus.btn_prev) begin
                    sel_d = sel_forward(sel_q, NUM_WORDS);
                end else if (bus.btn_prev && !bus.btn_next) begin
                    sel_d = sel_backward(sel_q, NUM_WORDS);
                end
            end else if (tick) begin
                sel_d = sel_forward(sel_q, NUM_WORDS);
            end
        end
    end

    // Outputs derive from the next-state values so word, index and LEDs stay coherent.
    always_comb begin
        word_d  = '0;
        led_d   = '0;
        valid_d = (state_d != EMPTY);

        if (valid_d) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (sel_d == SEL_W'(i)) begin
                    word_d = digest_d[i*WORD_W +: WORD_W];
                end
            end
            for (int i = 0; i < LED_W; i++) begin
                led_d[i] = (sel_d == SEL_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            digest_q <= '0;
            sel_q    <= '0;
            word_q   <= '0;
            led_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            digest_q <= digest_d;
            sel_q    <= sel_d;
            word_q   <= word_d;
            led_q    <= led_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.sel        = sel_q;
    assign bus.led        = led_q;
    assign bus.word_valid = valid_q;

endmodule

// File: tb/tb_digest_display_ctrl.sv
// Self-checking bench for digest_display_ctrl: directed table, multi-cycle
// corner sequences, and randomized traffic against a behavioural model.
module tb_digest_display_ctrl;
    import digest_display_ctrl_pkg::*;

    localparam int DW = 256;
    localparam int NW = 5;
    localparam int ST = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    digest_display_ctrl_if #(.DIGEST_W(DW)) bus();

    digest_display_ctrl #(
        .DIGEST_W   (DW),
        .NUM_WORDS  (NW),
        .STEP_TICKS (ST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] cur_digest;

    // Behavioural model of what the display should show.
    bit          m_has;
    bit          m_auto;
    int          m_sel;
    int          m_timer;
    logic [31:0] m_words [NW];

    typedef struct {
        bit          c, dv, nx, pv, ae;
        logic [31:0] ew;
        logic [2:0]  es;
        logic [4:0]  el;
        logic        ev;
    } vec_t;

    vec_t vecs [10];

    function automatic void model_reset();
        m_has   = 1'b0;
        m_auto  = 1'b0;
        m_sel   = 0;
        m_timer = 0;
        for (int i = 0; i < NW; i++) m_words[i] = '0;
    endfunction

    function automatic void model_step(bit c, bit dv, bit nx, bit pv, bit ae);
        if (c) begin
            model_reset();
        end else if (dv) begin
            for (int i = 0; i < NW; i++) m_words[i] = cur_digest[32*i +: 32];
            m_has   = 1'b1;
            m_auto  = ae;
            m_sel   = 0;
            m_timer = 0;
        end else if (m_has) begin
            if (nx || pv) begin
                if (nx && !pv)      m_sel = (m_sel + 1) % NW;
                else if (pv && !nx) m_sel = (m_sel + NW - 1) % NW;
                m_timer = 0;
            end else if (m_auto && ae) begin
                if (m_timer == ST - 1) begin
                    m_sel   = (m_sel + 1) % NW;
                    m_timer = 0;
                end else begin
                    m_timer++;
                end
            end else begin
                m_timer = 0;
            end
            m_auto = ae;
        end
    endfunction

    task automatic applyStimulus(input bit c, input bit dv, input bit nx,
                                 input bit pv, input bit ae);
        bus.clear        = c;
        bus.digest_valid = dv;
        bus.btn_next     = nx;
        bus.btn_prev     = pv;
        bus.auto_en      = ae;
        bus.digest_in    = cur_digest;
        @(posedge clk);
        model_step(c, dv, nx, pv, ae);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] ew,
                               input logic [2:0] es, input logic [4:0] el,
                               input logic ev);
        total++;
        if (bus.word_out !== ew || bus.sel !== es || bus.led !== el || bus.word_valid !== ev) begin
            bad++;
            $display("[TB] FAIL %s: got word=%h sel=%0d led=%b valid=%b, expected word=%h sel=%0d led=%b valid=%b",
                     name, bus.word_out, bus.sel, bus.led, bus.word_valid, ew, es, el, ev);
        end
    endtask

    task automatic checkModel(input string name);
        logic [31:0] ew;
        logic [4:0]  el;
        ew = m_has ? m_words[m_sel] : 32'h0;
        el = (m_has && m_sel < 5) ? 5'(1 << m_sel) : 5'b0;
        checkOutput(name, ew, 3'(m_sel), el, m_has);
    endtask

    task automatic setPatternDigest();
        for (int i = 0; i < DW / 32; i++) cur_digest[32*i +: 32] = 32'hA000_0000 + 32'(i);
    endtask

    initial begin
        bus.clear        = 1'b0;
        bus.digest_valid = 1'b0;
        bus.btn_next     = 1'b0;
        bus.btn_prev     = 1'b0;
        bus.auto_en      = 1'b0;
        setPatternDigest();
        bus.digest_in    = cur_digest;
        model_reset();

        vecs[0] = '{0,1,0,0,0, 32'hA000_0000, 3'd0, 5'b00001, 1'b1};
        vecs[1] = '{0,0,1,0,0, 32'hA000_0001, 3'd1, 5'b00010, 1'b1};
        vecs[2] = '{0,0,1,0,0, 32'hA000_0002, 3'd2, 5'b00100, 1'b1};
        vecs[3] = '{0,0,1,0,0, 32'hA000_0003, 3'd3, 5'b01000, 1'b1};
        vecs[4] = '{0,0,1,0,0, 32'hA000_0004, 3'd4, 5'b10000, 1'b1};
        vecs[5] = '{0,0,1,0,0, 32'hA000_0000, 3'd0, 5'b00001, 1'b1};
        vecs[6] = '{0,0,0,1,0, 32'hA000_0004, 3'd4, 5'b10000, 1'b1};
        vecs[7] = '{0,0,1,1,0, 32'hA000_0004, 3'd4, 5'b10000, 1'b1};
        vecs[8] = '{0,0,0,0,0, 32'hA000_0004, 3'd4, 5'b10000, 1'b1};
        vecs[9] = '{1,1,0,0,0, 32'h0,         3'd0, 5'b00000, 1'b0};

        #12;
        checkOutput("reset", 32'h0, 3'd0, 5'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Directed table: capture, manual stepping, both buttons, clear+capture.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].c, vecs[i].dv, vecs[i].nx, vecs[i].pv, vecs[i].ae);
            checkOutput($sformatf("vec%0d", i), vecs[i].ew, vecs[i].es, vecs[i].el, vecs[i].ev);
        end

        // EMPTY ignores buttons and auto_en.
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("empty_btn", 32'h0, 3'd0, 5'b0, 1'b0);
        for (int k = 0; k < 19; k++) begin
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput($sformatf("empty_auto%0d", k), 32'h0, 3'd0, 5'b0, 1'b0);
        end

        // Timed auto-advance: one step every ST cycles, wrapping past the last word.
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("auto_capture", 32'hA000_0000, 3'd0, 5'b00001, 1'b1);
        for (int k = 1; k <= 26; k++) begin
            int s;
            s = (k / ST) % NW;
            applyStimulus(0, 0, 0, 0, 1);
            checkOutput($sformatf("auto_k%0d", k), 32'hA000_0000 + 32'(s), 3'(s), 5'(1 << s), 1'b1);
        end
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            checkOutput($sformatf("freeze%0d", k), 32'hA000_0001, 3'd1, 5'b00010, 1'b1);
        end

        // Button arriving on the timer's terminal cycle gives exactly one step.
        applyStimulus(0, 1, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("pre_terminal", 32'hA000_0000, 3'd0, 5'b00001, 1'b1);
        applyStimulus(0, 0, 1, 0, 1);
        checkOutput("btn_on_terminal", 32'hA000_0001, 3'd1, 5'b00010, 1'b1);
        repeat (3) applyStimulus(0, 0, 0, 0, 1);
        checkOutput("timer_restarted", 32'hA000_0001, 3'd1, 5'b00010, 1'b1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("next_tick", 32'hA000_0002, 3'd2, 5'b00100, 1'b1);

        // Asynchronous reset mid-AUTO with sel=3.
        applyStimulus(0, 1, 0, 0, 1);
        repeat (3) applyStimulus(0, 0, 1, 0, 1);
        checkOutput("pre_reset_sel3", 32'hA000_0003, 3'd3, 5'b01000, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checkOutput("async_reset", 32'h0, 3'd0, 5'b0, 1'b0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 0, 1);
            checkOutput($sformatf("post_reset%0d", k), 32'h0, 3'd0, 5'b0, 1'b0);
        end

        // Randomized traffic against the model.
        begin
            bit ae;
            ae = 1'b0;
            for (int k = 0; k < 400; k++) begin
                bit c, dv, nx, pv;
                c  = ($urandom % 40) == 0;
                dv = ($urandom % 15) == 0;
                nx = ($urandom % 6) == 0;
                pv = ($urandom % 6) == 0;
                if (($urandom % 20) == 0) ae = ~ae;
                if (dv) begin
                    for (int i = 0; i < DW / 32; i++) cur_digest[32*i +: 32] = $urandom;
                end
                applyStimulus(c, dv, nx, pv, ae);
                checkModel($sformatf("rand%0d", k));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
